// File: rtl/adc_chip_responder.sv
`default_nettype none
// ============================================================================
//  Module      : adc_chip_responder
//  Description : Chip end of the ADC SPI link. Shifts in a 16-bit command
//                while chip select is low, decodes it on the 16th bit and
//                returns a ramp sample or register value on MISO for the
//                following 16 cycles. Flags frame completion and length errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_chip_responder #(
   parameter logic [7:0]  CHIP_ID     = 8'hA5,
   parameter logic [13:0] SAMPLE_INIT = 14'd0,
   parameter int          FRAME_BITS  = 33
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_adc_chip_select_n,
   input  logic        i_adc_chip_data,
   output logic        o_adc_chip_data,
   output logic        o_cmd_valid,
   output logic [15:0] o_cmd_data,
   output logic        o_frame_done,
   output logic        o_frame_error
);

   localparam logic [5:0] c_cnt_max       = 6'd63;
   localparam logic [5:0] c_cnt_last_cmd  = 6'd15;
   localparam logic [5:0] c_cnt_last_resp = 6'd30;
   localparam logic [3:0] c_op_convert    = 4'b0001;
   localparam logic [3:0] c_op_write      = 4'b0010;
   localparam logic [3:0] c_op_read       = 4'b0011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_armed;
   logic [5:0]  r_bit_cnt;
   logic [14:0] r_cmd_sr;
   logic [15:0] r_resp_sr;
   logic [13:0] r_ramp [0:1];
   logic [7:0]  r_regs [0:15];

   logic        w_active;
   logic        w_decode;
   logic        w_frame_end;
   logic [15:0] w_cmd;
   logic [15:0] w_resp;
   logic        w_ch;
   logic [3:0]  w_addr;
   logic [7:0]  w_reg_rd;
   logic [13:0] w_ramp_next;
   logic        w_ramp_en;
   logic        w_reg_wr;

   // A bit is only counted once the link has seen cs_n high since reset
   assign w_active    = r_armed & ~i_adc_chip_select_n;
   // The edge that captures cmd bit 0 is the decode edge
   assign w_decode    = w_active & (r_bit_cnt == c_cnt_last_cmd);
   assign w_cmd       = {r_cmd_sr, i_adc_chip_data};
   // First high cs_n after a frame that actually started
   assign w_frame_end = i_adc_chip_select_n & ((r_state == S_CMD) | (r_state == S_RESP));

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state: DONE behaves like IDLE so a back-to-back frame keeps its first bit
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_state_next = w_active ? S_CMD : S_IDLE;
         end
         S_CMD: begin
            if (i_adc_chip_select_n) begin
               w_state_next = S_DONE;
            end else if (r_bit_cnt == c_cnt_last_cmd) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (i_adc_chip_select_n) begin
               w_state_next = S_DONE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Command decode: response word and side effects for the current command
   always_comb begin
      w_ch        = w_cmd[8];
      w_addr      = w_cmd[11:8];
      w_reg_rd    = (w_addr == 4'd0) ? CHIP_ID : r_regs[w_addr];
      w_ramp_next = r_ramp[w_ch] + {10'd0, w_cmd[3:0]} + 14'd1;
      w_resp      = 16'hFFFF;
      w_ramp_en   = 1'b0;
      w_reg_wr    = 1'b0;
      case (w_cmd[15:12])
         c_op_convert: begin
            w_resp    = {2'b00, r_ramp[w_ch]};
            w_ramp_en = 1'b1;
         end
         c_op_write: begin
            w_resp   = {8'h00, w_reg_rd};
            w_reg_wr = (w_addr != 4'd0);
         end
         c_op_read: begin
            w_resp = {8'h00, w_reg_rd};
         end
         default: begin
            w_resp = 16'hFFFF;
         end
      endcase
   end

   // Arming, saturating bit counter and command shift-in
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_armed   <= 1'b0;
         r_bit_cnt <= 6'd0;
         r_cmd_sr  <= 15'd0;
      end else if (i_adc_chip_select_n) begin
         r_armed   <= 1'b1;
         r_bit_cnt <= 6'd0;
      end else if (r_armed) begin
         if (r_bit_cnt != c_cnt_max) begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
         end
         if (r_bit_cnt <= c_cnt_last_cmd) begin
            r_cmd_sr <= w_cmd[14:0];
         end
      end
   end

   // Command reporting, MISO serialiser and frame status pulses
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_cmd_valid     <= 1'b0;
         o_cmd_data      <= 16'd0;
         o_adc_chip_data <= 1'b0;
         r_resp_sr       <= 16'd0;
         o_frame_done    <= 1'b0;
         o_frame_error   <= 1'b0;
      end else begin
         o_cmd_valid   <= w_decode;
         o_frame_done  <= w_frame_end;
         o_frame_error <= w_frame_end & ({26'd0, r_bit_cnt} != FRAME_BITS);
         if (w_decode) begin
            o_cmd_data      <= w_cmd;
            o_adc_chip_data <= w_resp[15];
            r_resp_sr       <= {w_resp[14:0], 1'b0};
         end else if (w_active && (r_bit_cnt > c_cnt_last_cmd) &&
                      (r_bit_cnt <= c_cnt_last_resp)) begin
            o_adc_chip_data <= r_resp_sr[15];
            r_resp_sr       <= {r_resp_sr[14:0], 1'b0};
         end else begin
            o_adc_chip_data <= 1'b0;
         end
      end
   end

   // Ramp counters and register file, updated only on a completed decode
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_ramp[i] <= SAMPLE_INIT;
         end
         for (int i = 0; i < 16; i++) begin
            r_regs[i] <= 8'd0;
         end
      end else if (w_decode) begin
         if (w_ramp_en) begin
            r_ramp[w_ch] <= w_ramp_next;
         end
         if (w_reg_wr) begin
            r_regs[w_addr] <= w_cmd[7:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adc_chip_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_chip_responder
//  Description : Scoreboard bench for adc_chip_responder. The stimulus side
//                computes expected responses from a behavioural chip model
//                and queues them; monitors compare when the DUT reports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_chip_responder;

   localparam logic [7:0]  c_chip_id     = 8'hA5;
   localparam logic [13:0] c_sample_init = 14'd0;
   localparam int          c_frame_bits  = 33;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic        cmd_valid;
   logic [15:0] cmd_data;
   logic        frame_done;
   logic        frame_error;

   always #5 clk = ~clk;

   adc_chip_responder #(
      .CHIP_ID     (c_chip_id),
      .SAMPLE_INIT (c_sample_init),
      .FRAME_BITS  (c_frame_bits)
   ) dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_adc_chip_select_n (cs_n),
      .i_adc_chip_data     (mosi),
      .o_adc_chip_data     (miso),
      .o_cmd_valid         (cmd_valid),
      .o_cmd_data          (cmd_data),
      .o_frame_done        (frame_done),
      .o_frame_error       (frame_error)
   );

   typedef struct {
      logic [15:0] cmd;
      logic [15:0] resp;
      int          nbits;   // leading response bits expected on MISO
   } exp_cmd_t;

   int          n_checks = 0;
   int          n_errors = 0;
   exp_cmd_t    exp_cmd_q [$];
   bit          exp_err_q [$];
   logic [13:0] m_ramp [2];
   logic [7:0]  m_regs [16];
   logic        cs_at_edge = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural chip model ----------------
   task automatic model_reset();
      for (int i = 0; i < 2; i++) m_ramp[i] = c_sample_init;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
   endtask

   task automatic model_exec(input logic [15:0] cmd, output logic [15:0] resp);
      int a;
      int ch;
      int sum;
      logic [7:0] cur;
      a   = int'(cmd[11:8]);
      ch  = int'(cmd[8]);
      cur = (a == 0) ? c_chip_id : m_regs[a];
      case (cmd[15:12])
         4'h1: begin
            resp       = {2'b00, m_ramp[ch]};
            sum        = int'(m_ramp[ch]) + int'(cmd[3:0]) + 1;
            m_ramp[ch] = 14'(sum % 16384);
         end
         4'h2: begin
            resp = {8'h00, cur};
            if (a != 0) m_regs[a] = cmd[7:0];
         end
         4'h3: resp = {8'h00, cur};
         default: resp = 16'hFFFF;
      endcase
   endtask

   // ---------------- stimulus ----------------
   // Called at posedge+2; drives len cs_n-low cycles, then gap high cycles.
   task automatic run_frame(input logic [15:0] cmd, input int len, input int gap);
      exp_cmd_t e;
      logic [15:0] resp;
      if (len >= 16) begin
         model_exec(cmd, resp);
         e.cmd = cmd; e.resp = resp; e.nbits = 16;
         exp_cmd_q.push_back(e);
      end
      exp_err_q.push_back(len != c_frame_bits);
      for (int k = 0; k < len; k++) begin
         cs_n = 1'b0;
         mosi = (k < 16) ? cmd[15-k] : 1'($urandom);
         @(posedge clk); #2;
      end
      cs_n = 1'b1;
      mosi = 1'($urandom);
      repeat (gap) begin @(posedge clk); #2; end
   endtask

   // Reset lands at count 20; released with cs_n still low.
   task automatic run_reset_frame(input logic [15:0] cmd);
      exp_cmd_t e;
      logic [15:0] resp;
      model_exec(cmd, resp);
      e.cmd = cmd; e.resp = resp; e.nbits = 5;
      exp_cmd_q.push_back(e);
      for (int k = 0; k < 20; k++) begin
         cs_n = 1'b0;
         mosi = (k < 16) ? cmd[15-k] : 1'($urandom);
         @(posedge clk); #2;
      end
      rst_n = 1'b0;
      model_reset();
      repeat (3) begin @(posedge clk); #2; mosi = 1'($urandom); end
      rst_n = 1'b1;
      repeat (8) begin @(posedge clk); #2; mosi = 1'($urandom); end
      cs_n = 1'b1;
      repeat (3) begin @(posedge clk); #2; end
   endtask

   // ---------------- monitors ----------------
   always @(posedge clk) cs_at_edge <= cs_n;

   // On each decode: check command word, then MISO bits until cs_n rises
   always begin : mon_cmd
      exp_cmd_t    e;
      int          j;
      int          n;
      logic [15:0] obs;
      logic [15:0] mask;
      bit          tail_bad;
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
         if (exp_cmd_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL cmd_valid: unexpected pulse with cmd_data %h, required none", cmd_data);
         end else begin
            e = exp_cmd_q.pop_front();
            check("cmd_data", 32'(cmd_data), 32'(e.cmd));
            j = 0; obs = 16'h0; tail_bad = 1'b0;
            while (cs_at_edge === 1'b0 && j <= 80) begin
               if (j < e.nbits) obs[15-j] = miso;
               else if (miso !== 1'b0) tail_bad = 1'b1;
               j++;
               @(negedge clk);
            end
            if (j > 80) begin
               n_checks++;
               n_errors++;
               $display("FAIL miso_window: cs_n still low after %0d cycles, required a rise", j);
            end
            check("miso_cs_high", 32'(miso), 32'd0);
            n    = (j < e.nbits) ? j : e.nbits;
            mask = (n >= 16) ? 16'hFFFF : ~(16'hFFFF >> n);
            check("miso_word", 32'(obs & mask), 32'(e.resp & mask));
            if (j > e.nbits) check("miso_tail_zero", 32'(tail_bad), 32'd0);
         end
      end
   end

   // Frame status pulses
   always begin : mon_done
      @(negedge clk);
      if (frame_done === 1'b1) begin
         if (exp_err_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_done: unexpected pulse, required none");
         end else begin
            check("frame_error", 32'(frame_error), 32'(exp_err_q.pop_front()));
         end
      end else if (frame_error !== 1'b0) begin
         n_checks++;
         n_errors++;
         $display("FAIL frame_error_alone: got %b without frame_done, required 0", frame_error);
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] cmd;
      int          len;
      int          sel;
      rst_n = 1'b1;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_miso", 32'(miso), 32'd0);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_data", 32'(cmd_data), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_frame_error", 32'(frame_error), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #2; end

      run_frame(16'h1000, 33, 2);
      run_frame(16'h1000, 33, 2);
      repeat (3) run_frame(16'h1103, 33, 2);
      run_frame(16'h1000, 33, 2);
      run_frame(16'h253C, 33, 2);
      run_frame(16'h3500, 33, 2);
      run_frame(16'h3000, 33, 2);
      run_frame(16'h20FF, 33, 2);
      run_frame(16'h3000, 33, 2);
      run_frame(16'h1000, 10, 2);
      run_frame(16'h1000, 33, 2);
      run_reset_frame(16'h1000);
      run_frame(16'h1000, 33, 2);
      run_frame(16'h7000, 33, 2);
      run_frame(16'h1000, 40, 2);
      run_frame(16'h3500, 33, 1);

      for (int i = 0; i < 60; i++) begin
         cmd = 16'($urandom);
         sel = $urandom_range(0, 6);
         if (sel < 2)      cmd[15:12] = 4'h1;
         else if (sel < 4) cmd[15:12] = 4'h2;
         else if (sel < 6) cmd[15:12] = 4'h3;
         sel = $urandom_range(0, 9);
         if (sel < 6)       len = c_frame_bits;
         else if (sel == 6) len = $urandom_range(1, 15);
         else if (sel == 7) len = $urandom_range(16, 32);
         else if (sel == 8) len = $urandom_range(34, 63);
         else               len = 70;
         run_frame(cmd, len, $urandom_range(1, 4));
      end

      repeat (10) begin @(posedge clk); #2; end
      check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
      check("done_queue_drained", 32'(exp_err_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      n_errors++;
      $display("FAIL timeout: simulation still running at %0t, required completion", $time);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "time limit reached");
   end

endmodule
`default_nettype wire
